// File: rtl/data_memory.sv
// Multi-cycle RV32 data memory: IDLE/BUSY/DONE handshake with configurable latency,
// byte/half/word little-endian access, and rejection of misaligned or out-of-range requests.
module data_memory #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 3
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        MEM_READ,
   input  logic        MEM_WRITE,
   input  logic [2:0]  FUNCT3,
   input  logic [31:0] ADDRESS,
   input  logic [31:0] WRITE_DATA,
   output logic [31:0] READ_DATA,
   output logic        BUSYWAIT,
   output logic        ERROR
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [31:0]   addr_q, wdata_q;
   logic [2:0]    funct3_q;
   logic          rd_q, wr_q;

   logic [31:0]   mem_q [DEPTH_WORDS] = '{default: 32'h0};

   logic          req, bad, do_access;
   logic [AW-1:0] widx;
   logic [3:0]    be;
   logic [31:0]   wlanes;

   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  a);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[8*a +: 8];
      h = a[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'h0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'h0, h};
         default: return word;
      endcase
   endfunction

   assign req  = MEM_READ | MEM_WRITE;
   assign widx = addr_q[AW+1:2];

   // Rejection is decided only from the latched request.
   always_comb begin
      bad = 1'b0;
      if (rd_q && wr_q)                            bad = 1'b1;
      if (|addr_q[31:AW+2])                        bad = 1'b1;
      if (funct3_q[1:0] == 2'b01 && addr_q[0])     bad = 1'b1;
      if (funct3_q[1:0] == 2'b10 && |addr_q[1:0])  bad = 1'b1;
      if (funct3_q == 3'b011 || funct3_q[2:1] == 2'b11) bad = 1'b1;
      if (wr_q && funct3_q[2])                     bad = 1'b1;
   end

   always_comb begin
      be     = 4'b0000;
      wlanes = wdata_q;
      case (funct3_q[1:0])
         2'b00: begin
            be     = 4'b0001 << addr_q[1:0];
            wlanes = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be     = addr_q[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{wdata_q[15:0]}};
         end
         default: be = 4'b1111;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      err_d     = 1'b0;
      do_access = 1'b0;
      case (state_q)
         S_IDLE: if (req) begin
            state_d = S_BUSY;
            cnt_d   = CW'(LATENCY - 1);
         end
         S_BUSY: begin
            if (cnt_q == '0) begin
               state_d   = S_DONE;
               do_access = 1'b1;
               if (bad) begin
                  err_d   = 1'b1;
                  rdata_d = 32'h0;
               end else if (rd_q) begin
                  rdata_d = load_extend(mem_q[widx], funct3_q, addr_q[1:0]);
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (state_q == S_IDLE && req) begin
         addr_q   <= ADDRESS;
         wdata_q  <= WRITE_DATA;
         funct3_q <= FUNCT3;
         rd_q     <= MEM_READ;
         wr_q     <= MEM_WRITE;
      end
   end

   // Reset forces the FSM out of BUSY asynchronously, so a pending store never commits.
   always_ff @(posedge CLK) begin
      if (do_access && wr_q && !bad) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[widx][8*b +: 8] <= wlanes[8*b +: 8];
         end
      end
   end

   always_comb begin
      BUSYWAIT = 1'b0;
      if (RESET_N) begin
         if (state_q == S_IDLE)      BUSYWAIT = req;
         else if (state_q == S_BUSY) BUSYWAIT = 1'b1;
      end
   end

   assign READ_DATA = rdata_q;
   assign ERROR     = err_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: a byte-level reference model predicts load data,
// error pulses and stall length for every request.
module tb_data_memory;

   logic        CLK;
   logic        RESET_N;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [2:0]  FUNCT3;
   logic [31:0] ADDRESS;
   logic [31:0] WRITE_DATA;
   logic [31:0] READ_DATA;
   logic        BUSYWAIT;
   logic        ERROR;

   data_memory #(.DEPTH_WORDS(256), .LATENCY(3)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
      .FUNCT3(FUNCT3), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
      .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT), .ERROR(ERROR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  mdl [0:1023];
   logic [31:0] last_rd;
   int          n_vec;
   int          n_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic exp_bad(input logic rd, input logic wr,
                                    input logic [2:0] f3, input logic [31:0] a);
      logic r;
      r = 1'b0;
      if (rd && wr) r = 1'b1;
      if (a >= 32'd1024) r = 1'b1;
      case (f3)
         3'b000: ;
         3'b001: if (a[0]) r = 1'b1;
         3'b010: if (a[1:0] != 2'b00) r = 1'b1;
         3'b100: if (wr) r = 1'b1;
         3'b101: if (wr || a[0]) r = 1'b1;
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
      int i;
      logic [7:0]  b0;
      logic [15:0] h;
      i  = int'(a[9:0]);
      b0 = mdl[i];
      case (f3)
         3'b000: return {{24{b0[7]}}, b0};
         3'b100: return {24'h0, b0};
         3'b001: begin h = {mdl[i+1], mdl[i]}; return {{16{h[15]}}, h}; end
         3'b101: begin h = {mdl[i+1], mdl[i]}; return {16'h0, h}; end
         default: return {mdl[i+3], mdl[i+2], mdl[i+1], mdl[i]};
      endcase
   endfunction

   // Starts on a falling edge; returns on the falling edge of the IDLE cycle after DONE.
   task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
      exp_t e;
      exp_t got;
      int   n;
      int   i;
      e.err = exp_bad(rd, wr, f3, a);
      if (e.err) begin
         e.rdata = 32'h0;
      end else if (rd) begin
         e.rdata = exp_load(f3, a);
      end else begin
         e.rdata = last_rd;
         i = int'(a[9:0]);
         mdl[i] = wd[7:0];
         if (f3 != 3'b000) mdl[i+1] = wd[15:8];
         if (f3 == 3'b010) begin
            mdl[i+2] = wd[23:16];
            mdl[i+3] = wd[31:24];
         end
      end
      last_rd = e.rdata;
      sb.push_back(e);

      MEM_READ   = rd;
      MEM_WRITE  = wr;
      FUNCT3     = f3;
      ADDRESS    = a;
      WRITE_DATA = wd;
      #1;
      n = 0;
      while (BUSYWAIT && n < 20) begin
         n++;
         @(negedge CLK);
         #1;
         if (n >= 2) begin
            ADDRESS    = $urandom;
            WRITE_DATA = $urandom;
            FUNCT3     = 3'($urandom_range(0, 7));
         end
      end
      got.rdata = READ_DATA;
      got.err   = ERROR;
      e = sb.pop_front();
      chk($sformatf("stall@%h", a), 32'(n), 32'd4);
      chk($sformatf("rdata@%h", a), got.rdata, e.rdata);
      chk($sformatf("error@%h", a), {31'h0, got.err}, {31'h0, e.err});
      MEM_READ  = 1'b0;
      MEM_WRITE = 1'b0;
      @(negedge CLK);
      chk("error_clears", {31'h0, ERROR}, 32'h0);
      chk("busy_idle", {31'h0, BUSYWAIT}, 32'h0);
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic        wr;
      n_vec   = 0;
      n_err   = 0;
      last_rd = 32'h0;
      for (int k = 0; k < 1024; k++) mdl[k] = 8'h0;

      RESET_N    = 1'b0;
      MEM_READ   = 1'b1;
      MEM_WRITE  = 1'b0;
      FUNCT3     = 3'b010;
      ADDRESS    = 32'h0;
      WRITE_DATA = 32'h0;
      #2;
      chk("rst_busy", {31'h0, BUSYWAIT}, 32'h0);
      chk("rst_rdata", READ_DATA, 32'h0);
      chk("rst_error", {31'h0, ERROR}, 32'h0);
      MEM_READ = 1'b0;
      #9;
      RESET_N = 1'b1;
      @(negedge CLK);
      chk("idle_busy", {31'h0, BUSYWAIT}, 32'h0);

      access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      chk("lw_deadbeef", READ_DATA, 32'hDEADBEEF);

      access(1'b0, 1'b1, 3'b000, 32'h21, 32'h80);
      access(1'b1, 1'b0, 3'b000, 32'h21, 32'h0);
      chk("lb_const", READ_DATA, 32'hFFFFFF80);
      access(1'b1, 1'b0, 3'b100, 32'h21, 32'h0);
      chk("lbu_const", READ_DATA, 32'h00000080);
      access(1'b0, 1'b1, 3'b001, 32'h22, 32'h8001);
      access(1'b1, 1'b0, 3'b001, 32'h22, 32'h0);
      chk("lh_const", READ_DATA, 32'hFFFF8001);
      access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
      chk("lw_const", READ_DATA, 32'h80018000);
      access(1'b1, 1'b0, 3'b101, 32'h22, 32'h0);

      access(1'b0, 1'b1, 3'b010, 32'h14, 32'hCAFEF00D);
      access(1'b1, 1'b0, 3'b010, 32'h13, 32'h0);
      access(1'b0, 1'b1, 3'b001, 32'h15, 32'hFFFF);
      access(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
      chk("word14_kept", READ_DATA, 32'hCAFEF00D);

      access(1'b0, 1'b1, 3'b010, 32'h0, 32'h11223344);
      access(1'b0, 1'b1, 3'b010, 32'h400, 32'h55667788);
      access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
      chk("word0_kept", READ_DATA, 32'h11223344);

      access(1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
      access(1'b1, 1'b1, 3'b010, 32'h0, 32'h0);
      access(1'b0, 1'b1, 3'b100, 32'h8, 32'h77);
      access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);

      // Reset arrives while a store is in BUSY.
      MEM_WRITE  = 1'b1;
      FUNCT3     = 3'b010;
      ADDRESS    = 32'h30;
      WRITE_DATA = 32'h12345678;
      @(negedge CLK);
      @(negedge CLK);
      RESET_N = 1'b0;
      #1;
      chk("midrst_busy", {31'h0, BUSYWAIT}, 32'h0);
      chk("midrst_rdata", READ_DATA, 32'h0);
      chk("midrst_error", {31'h0, ERROR}, 32'h0);
      MEM_WRITE = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;
      last_rd = 32'h0;
      @(negedge CLK);
      access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
      chk("store_discarded", READ_DATA, 32'h0);

      for (int t = 0; t < 12; t++) begin
         wr = 1'($urandom_range(0, 1));
         case ($urandom_range(0, wr ? 2 : 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = 3'b100;
            default: f3 = 3'b101;
         endcase
         a = 32'($urandom_range(0, 1023));
         if (f3[1:0] == 2'b01) a[0] = 1'b0;
         if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
         access(!wr, wr, f3, a, $urandom);
      end

      if (sb.size() != 0) chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
